// File: rtl/dvi_tmds_encoder_pkg.sv
// Shared TMDS constants, types and small helpers for the DVI encoder.
// Used by tmds_channel_enc and dvi_tmds_encoder.
package dvi_tmds_encoder_pkg;

    localparam int SYM_W  = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;

    localparam logic [SYM_W-1:0] TMDS_CTRL_00   = 10'b1101010100;
    localparam logic [SYM_W-1:0] TMDS_CTRL_01   = 10'b0010101011;
    localparam logic [SYM_W-1:0] TMDS_CTRL_10   = 10'b0101010100;
    localparam logic [SYM_W-1:0] TMDS_CTRL_11   = 10'b1010101011;
    localparam logic [SYM_W-1:0] TMDS_RESET_SYM = TMDS_CTRL_00;

    typedef logic signed [CNT_W-1:0] cnt_t;

    // First pipeline stage: transition-minimised word plus the control info riding with it.
    typedef struct packed {
        logic       de;
        logic [1:0] c;
        logic [8:0] qm;
    } stage1_t;

    function automatic logic [3:0] ones8(input logic [DATA_W-1:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < DATA_W; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    function automatic logic [SYM_W-1:0] ctrl_symbol(input logic [1:0] c);
        logic [SYM_W-1:0] sym;
        case (c)
            2'b00:   sym = TMDS_CTRL_00;
            2'b01:   sym = TMDS_CTRL_01;
            2'b10:   sym = TMDS_CTRL_10;
            default: sym = TMDS_CTRL_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 builds q_m, stage 2 DC-balances it against the
// running disparity count (or emits a control code during blanking).
module tmds_channel_enc
    import dvi_tmds_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de,
    input  logic [DATA_W-1:0] d,
    input  logic [1:0]        c,
    output logic [SYM_W-1:0]  q
);

    stage1_t          s1;
    stage1_t          s1_next;
    cnt_t             cnt;
    cnt_t             cnt_next;
    logic [SYM_W-1:0] q_next;

    logic [3:0] n1d;
    logic       use_xnor;
    logic       chain;

    logic [3:0] n1q;
    logic       q8;
    cnt_t       ones_s;
    cnt_t       zeros_s;
    cnt_t       diff;
    cnt_t       two_q8;
    cnt_t       two_nq8;
    logic       cnt_pos;
    logic       cnt_neg;
    logic       diff_pos;
    logic       diff_neg;

    always_comb begin
        s1_next    = '0;
        s1_next.de = de;
        s1_next.c  = c;
        n1d        = ones8(d);
        use_xnor   = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        chain      = d[0];
        s1_next.qm[0] = d[0];
        for (int i = 1; i < DATA_W; i++) begin
            chain = use_xnor ? ~(chain ^ d[i]) : (chain ^ d[i]);
            s1_next.qm[i] = chain;
        end
        s1_next.qm[8] = ~use_xnor;
    end

    // diff is (ones - zeros) of q_m[7:0]; everything fits comfortably in 5 signed bits.
    always_comb begin
        n1q      = ones8(s1.qm[7:0]);
        ones_s   = $signed({1'b0, n1q});
        zeros_s  = $signed({1'b0, 4'd8 - n1q});
        diff     = ones_s - zeros_s;
        q8       = s1.qm[8];
        two_q8   = $signed({3'b000, q8, 1'b0});
        two_nq8  = $signed({3'b000, ~q8, 1'b0});
        cnt_neg  = cnt[CNT_W-1];
        cnt_pos  = !cnt[CNT_W-1] && (cnt != '0);
        diff_neg = diff[CNT_W-1];
        diff_pos = !diff[CNT_W-1] && (diff != '0);

        q_next   = ctrl_symbol(s1.c);
        cnt_next = '0;
        if (s1.de) begin
            if ((cnt == '0) || (diff == '0)) begin
                q_next   = {~q8, q8, (q8 ? s1.qm[7:0] : ~s1.qm[7:0])};
                cnt_next = q8 ? (cnt + diff) : (cnt - diff);
            end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
                q_next   = {1'b1, q8, ~s1.qm[7:0]};
                cnt_next = cnt + two_q8 - diff;
            end else begin
                q_next   = {1'b0, q8, s1.qm[7:0]};
                cnt_next = cnt + diff - two_nq8;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= '0;
            q   <= TMDS_RESET_SYM;
            cnt <= '0;
        end else begin
            s1  <= s1_next;
            q   <= q_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder top: routes syncs onto the blue channel and instantiates three channel encoders.
// Define TMDS_SYNC_INVERT_EN to invert hsync/vsync before encoding (active-low sync timings).
module dvi_tmds_encoder
    import dvi_tmds_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de,
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] b,
    input  logic              hsync,
    input  logic              vsync,
    output logic [SYM_W-1:0]  tmds_r,
    output logic [SYM_W-1:0]  tmds_g,
    output logic [SYM_W-1:0]  tmds_b
);

    logic [1:0] c_blue;

`ifdef TMDS_SYNC_INVERT_EN
    assign c_blue = {~vsync, ~hsync};
`else
    assign c_blue = {vsync, hsync};
`endif

    tmds_channel_enc u_enc_r (
        .clk   (clk),
        .rst_n (rst_n),
        .de    (de),
        .d     (r),
        .c     (2'b00),
        .q     (tmds_r)
    );

    tmds_channel_enc u_enc_g (
        .clk   (clk),
        .rst_n (rst_n),
        .de    (de),
        .d     (g),
        .c     (2'b00),
        .q     (tmds_g)
    );

    tmds_channel_enc u_enc_b (
        .clk   (clk),
        .rst_n (rst_n),
        .de    (de),
        .d     (b),
        .c     (c_blue),
        .q     (tmds_b)
    );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Self-checking bench for dvi_tmds_encoder: directed vector table, mid-line reset,
// and a randomised multi-line frame compared against a behavioural TMDS model.
module tb_dvi_tmds_encoder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       de    = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] r     = 8'h00;
    logic [7:0] g     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic [9:0] tmds_r;
    logic [9:0] tmds_g;
    logic [9:0] tmds_b;

    int errors = 0;
    int checks = 0;

`ifdef TMDS_SYNC_INVERT_EN
    logic inv_sync = 1'b1;
`else
    logic inv_sync = 1'b0;
`endif

    logic [9:0] ctrl_code [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] reset_sym = 10'b1101010100;

    // Reference model state: one pixel waiting in stage 1, plus per-channel output and disparity.
    logic       m_de;
    logic [1:0] m_c   [3];
    logic [7:0] m_d   [3];
    int         m_cnt [3];
    logic [9:0] m_out [3];

    typedef struct {
        logic       de;
        logic       vs;
        logic       hs;
        logic [7:0] pix;
        logic [9:0] exp_b;
        logic [9:0] exp_rg;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [9];

    dvi_tmds_encoder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .de     (de),
        .r      (r),
        .g      (g),
        .b      (b),
        .hsync  (hsync),
        .vsync  (vsync),
        .tmds_r (tmds_r),
        .tmds_g (tmds_g),
        .tmds_b (tmds_b)
    );

    always #20 clk = ~clk;

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // q_m written as prefix parity of d; the XNOR chain flips every odd position.
    task automatic ref_encode(input logic [7:0] d, input logic en, input logic [1:0] c,
                              input int cnt_in, output logic [9:0] sym, output int cnt_out);
        int         n1d;
        int         n1q;
        int         n0q;
        logic       xnor_mode;
        logic       par;
        logic [8:0] qm;
        if (!en) begin
            sym     = ctrl_code[c];
            cnt_out = 0;
        end else begin
            n1d       = $countones(d);
            xnor_mode = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
            par       = 1'b0;
            for (int i = 0; i < 8; i++) begin
                par   = par ^ d[i];
                qm[i] = par ^ (xnor_mode && (i % 2 == 1));
            end
            qm[8] = !xnor_mode;
            n1q   = $countones(qm[7:0]);
            n0q   = 8 - n1q;
            if (cnt_in == 0 || n1q == n0q) begin
                sym     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                cnt_out = cnt_in + (qm[8] ? (n1q - n0q) : (n0q - n1q));
            end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
                sym     = {1'b1, qm[8], ~qm[7:0]};
                cnt_out = cnt_in + (qm[8] ? 2 : 0) + n0q - n1q;
            end else begin
                sym     = {1'b0, qm[8], qm[7:0]};
                cnt_out = cnt_in + n1q - n0q - (qm[8] ? 0 : 2);
            end
        end
    endtask

    task automatic model_step();
        logic [9:0] sym;
        int         nc;
        if (!rst_n) begin
            m_de = 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                m_out[ch] = reset_sym;
                m_cnt[ch] = 0;
                m_c[ch]   = 2'b00;
                m_d[ch]   = 8'h00;
            end
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                ref_encode(m_d[ch], m_de, m_c[ch], m_cnt[ch], sym, nc);
                m_out[ch] = sym;
                m_cnt[ch] = nc;
            end
            m_de    = de;
            m_d[0]  = r;
            m_d[1]  = g;
            m_d[2]  = b;
            m_c[0]  = 2'b00;
            m_c[1]  = 2'b00;
            m_c[2]  = {vsync ^ inv_sync, hsync ^ inv_sync};
        end
    endtask

    task automatic compare_model();
        int cr;
        int cg;
        int cb;
        cr = dut.u_enc_r.cnt;
        cg = dut.u_enc_g.cnt;
        cb = dut.u_enc_b.cnt;
        checkOutput("tmds_r", tmds_r, m_out[0]);
        checkOutput("tmds_g", tmds_g, m_out[1]);
        checkOutput("tmds_b", tmds_b, m_out[2]);
        checkValue("cnt_r", cr, m_cnt[0]);
        checkValue("cnt_g", cg, m_cnt[1]);
        checkValue("cnt_b", cb, m_cnt[2]);
        checkValue("cnt_bound", (cr >= -10 && cr <= 10 && cg >= -10 && cg <= 10 &&
                                 cb >= -10 && cb <= 10) ? 1 : 0, 1);
    endtask

    task automatic applyStimulus(input logic n_rst, input logic d_e, input logic hs, input logic vs,
                                 input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        rst_n = n_rst;
        de    = d_e;
        hsync = hs;
        vsync = vs;
        r     = rr;
        g     = gg;
        b     = bb;
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    function automatic logic [7:0] rand_pixel();
        logic [31:0] t;
        t = $urandom;
        case (t[9:8])
            2'b00:   return {8{t[0]}};
            2'b01:   return 8'b0000_1111 ^ {t[7:4], t[7:4]};
            default: return t[7:0];
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_r"}, tmds_r, 10'b1101010100);
        checkOutput({tag, "_g"}, tmds_g, 10'b1101010100);
        checkOutput({tag, "_b"}, tmds_b, 10'b1101010100);
        checkValue({tag, "_cnt_r"}, int'(dut.u_enc_r.cnt), 0);
        checkValue({tag, "_cnt_g"}, int'(dut.u_enc_g.cnt), 0);
        checkValue({tag, "_cnt_b"}, int'(dut.u_enc_b.cnt), 0);
    endtask

    initial begin
        logic [31:0] t;
        logic        act;
        logic        hs;
        logic        vs;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 10'b1101010100, 10'b1101010100, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 10'b0010101011, 10'b1101010100, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 10'b0101010100, 10'b1101010100, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h00, 10'b1010101011, 10'b1101010100, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'b0100000000, 10'b0100000000, -8};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'b1111111111, 10'b1111111111, 2};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 10'b1101010100, 10'b1101010100, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'hFF, 10'b1000000000, 10'b1000000000, -8};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 10'b1101010100, 10'b1101010100, 0};

        $display("[TB] start, sync invert = %0d", inv_sync);

        for (int i = 0; i < 3; i++) begin
            t = $urandom;
            applyStimulus(1'b0, t[0], t[1], t[2], t[15:8], t[23:16], t[31:24]);
        end
        check_reset_state("reset");

        for (int i = 0; i <= 9; i++) begin
            if (i < 9) begin
                applyStimulus(1'b1, vecs[i].de, vecs[i].hs ^ inv_sync, vecs[i].vs ^ inv_sync,
                              vecs[i].pix, vecs[i].pix, vecs[i].pix);
            end else begin
                applyStimulus(1'b1, 1'b0, inv_sync, inv_sync, 8'h00, 8'h00, 8'h00);
            end
            if (i > 0) begin
                checkOutput($sformatf("vec%0d_b", i - 1), tmds_b, vecs[i-1].exp_b);
                checkOutput($sformatf("vec%0d_r", i - 1), tmds_r, vecs[i-1].exp_rg);
                checkOutput($sformatf("vec%0d_g", i - 1), tmds_g, vecs[i-1].exp_rg);
                checkValue($sformatf("vec%0d_cnt", i - 1), int'(dut.u_enc_b.cnt), vecs[i-1].exp_cnt);
            end
        end

        // Scaled-down frame: 800-pixel lines with 640 active, 30 active lines then vertical blanking.
        for (int line = 0; line < 40; line++) begin
            for (int px = 0; px < 800; px++) begin
                act = (line < 30) && (px < 640);
                hs  = (px >= 656) && (px < 752);
                vs  = (line >= 32) && (line < 34);
                if (line == 3 && px == 300) begin
                    applyStimulus(1'b0, act, hs, vs, rand_pixel(), rand_pixel(), rand_pixel());
                    check_reset_state("midline_reset");
                end else begin
                    applyStimulus(1'b1, act, hs, vs, rand_pixel(), rand_pixel(), rand_pixel());
                end
            end
        end

        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            applyStimulus(1'b1, i[0], t[0], t[1], rand_pixel(), rand_pixel(), rand_pixel());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dvi_tmds_encoder.md
Name: dvi_tmds_encoder

Overview:
- Sits directly downstream of the sprite/background pixel pipeline and the sync generator.
- Consumes 8-bit R/G/B, hsync, vsync and display-enable in the pixel clock domain.
- Produces three 10-bit TMDS symbols per pixel clock per DVI 1.0: 8b/10b transition-minimised, DC-balanced.
- Feeds the 10:1 serialisers that drive the HDMI connector.

Parameters:
- none. Symbol width (10) and data width (8) are fixed by DVI.

Ports:
- clk  in  1  pixel clock, 25 MHz for 640x480
- rst_n  in  1  synchronous, active-low reset
- de  in  1  display enable; 1 = active pixel, 0 = blanking/control period
- r  in  8  red pixel
- g  in  8  green pixel
- b  in  8  blue pixel
- hsync  in  1  horizontal sync, encoded on blue C0
- vsync  in  1  vertical sync, encoded on blue C1
- tmds_r  out  10  red channel symbol, bit 0 transmitted first
- tmds_g  out  10  green channel symbol
- tmds_b  out  10  blue channel symbol

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n. All state is updated on the rising edge of clk.
- Reset values:
  - all tmds_* = 10'b1101010100 (control code C1C0=00)
  - all disparity counters = 0
  - pipeline registers cleared, de stage = 0
- Latency: fixed 2 clocks from inputs to tmds_*, identical for data and control. No handshake; one symbol per clock, always valid.
- Stage 1 (registered): latch de, C0/C1, and q_m[8:0] per channel.
  - n1d = number of ones in d.
  - If n1d>4, or n1d==4 and d[0]==0: XNOR chain, q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - Chain: q_m[0]=d[0]; q_m[i]=q_m[i-1] op d[i].
- Stage 2 (registered output): n1q/n0q are the ones/zeros counts of q_m[7:0]. cnt is signed, 5 bits, with range -10..+10 guaranteed.
  - Case cnt==0 or n1q==n0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q)
  - Else, case (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - out = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2*q_m[8] + (n0q-n1q)
  - Else:
    - out = {0, q_m[8], q_m[7:0]}
    - cnt += (n1q-n0q) - 2*(~q_m[8])
- Control period (de==0 at stage 2):
  - out = control code. C1C0: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
  - cnt forced to 0.
  - Blue uses C0=hsync, C1=vsync. Red and green use C1C0=00.
- Each channel has an independent cnt.
- de toggling every cycle is legal; each symbol follows the rules above with no extra delay.
- rst_n low mid-line: on the next edge, outputs go to reset values and cnt=0. Valid encoding resumes 2 clocks after rst_n rises.

Optional Feature:
- Macro TMDS_SYNC_INVERT_EN.
- Defined: hsync and vsync are inverted before stage 1, so blue C0=~hsync and C1=~vsync. This adapts to active-low sync timings.
- Undefined: syncs are passed through unchanged.
- Reset code is unchanged in both cases.

Decomposition:
- Shared package holds:
  - TMDS_CTRL_00/01/10/11 symbol constants
  - TMDS_RESET_SYM
  - symbol width constant (10)
  - cnt width constant (5)
- One sub-module, tmds_channel_enc, is instantiated three times.
  - Ports: clk, rst_n, de, d[7:0], c[1:0], q[9:0].
  - Contains the 2-stage pipeline and its own cnt.
- The top module only handles sync routing/inversion.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with random inputs -> all tmds_* = 1101010100, every cnt = 0.
- Control codes: de=0, sweep {vsync,hsync} 00/01/10/11 -> tmds_b = 1101010100 / 0010101011 / 0101010100 / 1010101011 two clocks later; tmds_r and tmds_g stay 1101010100.
- Balance on zeros: de=1, b=0x00 for 2 clocks from cnt=0 -> tmds_b = 0100000000 (cnt=-8), then 1111111111 (cnt=+2).
- XNOR path: de=1, b=0xFF from cnt=0 -> tmds_b = 1000000000, cnt=-8.
- Reset mid-line: rst_n=0 for 1 clock during de=1 random data -> next edge gives reset symbols and cnt=0; 2 clocks after release, outputs match the reference model.
- Random soak: 1e6 random pixels with realistic 640x480 blanking, compared against a behavioural model -> bit-exact match, |cnt| ≤ 10 at all times.
- Repeat the control-code test with TMDS_SYNC_INVERT_EN defined -> codes swapped accordingly.
